// File: rtl/wb_reg_bank_slave.sv
// Wishbone classic slave with NUM_REGS word registers; the last register is read-only (chronometer value).
// Optional error termination is enabled by defining WB_REG_BANK_ERR_EN.
module wb_reg_bank_slave #(
   parameter int WB_DATA_WIDTH    = 32,
   parameter int WB_ADDR_WIDTH    = 11,
   parameter int GRANULARITY      = 8,
   parameter int SLAVE_ADDR_WIDTH = 1,
   parameter int SLAVE_ADDR       = 0,
   parameter int NUM_REGS         = 4,
   parameter int WAIT_STATES      = 1
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic                                     cyc_i,
   input  logic                                     stb_i,
   input  logic                                     we_i,
   input  logic [WB_ADDR_WIDTH-1:0]                 addr_i,
   input  logic [WB_DATA_WIDTH/GRANULARITY-1:0]     sel_i,
   input  logic [WB_DATA_WIDTH-1:0]                 data_i,
   output logic [WB_DATA_WIDTH-1:0]                 data_o,
   output logic                                     ack_o,
`ifdef WB_REG_BANK_ERR_EN
   output logic                                     err_o,
`endif
   output logic [(NUM_REGS-1)*WB_DATA_WIDTH-1:0]    regs_o,
   output logic [NUM_REGS-2:0]                      wr_pulse_o,
   input  logic [15:0]                              value_i
);

   localparam int NL = WB_DATA_WIDTH / GRANULARITY;
   localparam int LB = $clog2(WB_DATA_WIDTH / 8);
   localparam int IW = $clog2(NUM_REGS);
   localparam int MSB = WB_ADDR_WIDTH - 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t                   state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;
   logic                     ack_q, ack_d;
   logic [NUM_REGS-2:0]      pulse_q, pulse_d;
   logic [WB_DATA_WIDTH-1:0] data_q, data_d;
   logic [WB_DATA_WIDTH-1:0] regs_q [NUM_REGS-1];
   logic [WB_DATA_WIDTH-1:0] regs_d [NUM_REGS-1];
`ifdef WB_REG_BANK_ERR_EN
   logic                     err_q, err_d;
`endif

   logic          hit;
   logic          go;
   logic [IW-1:0] idx;
   logic          idx_ok;
   logic          idx_ro;
   logic          unused_ok;

   assign hit    = cyc_i & stb_i & (addr_i[MSB -: SLAVE_ADDR_WIDTH] == SLAVE_ADDR_WIDTH'(SLAVE_ADDR));
   assign idx    = addr_i[LB +: IW];
   assign idx_ro = (idx == IW'(NUM_REGS - 1));
   assign unused_ok = ^{addr_i, idx_ok};

   always_comb begin
      idx_ok = 1'b0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (idx == IW'(k)) idx_ok = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      pulse_d = '0;
      data_d  = data_q;
      regs_d  = regs_q;
      go      = 1'b0;
`ifdef WB_REG_BANK_ERR_EN
      err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               if (WAIT_STATES == 0) begin
                  state_d = S_ACK;
                  go      = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end
            end
         end
         S_WAIT: begin
            if (!hit) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               state_d = S_ACK;
               go      = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // The transfer is committed on the same edge that enters ACK.
      if (go) begin
`ifdef WB_REG_BANK_ERR_EN
         if (!idx_ok || (we_i && idx_ro)) begin
            err_d  = 1'b1;
            data_d = '0;
         end else
`endif
         begin
            ack_d = 1'b1;
            if (we_i) begin
               for (int unsigned k = 0; k < NUM_REGS - 1; k++) begin
                  if (idx == IW'(k)) begin
                     pulse_d[k] = |sel_i;
                     for (int unsigned b = 0; b < NL; b++) begin
                        if (sel_i[b]) regs_d[k][b*GRANULARITY +: GRANULARITY] = data_i[b*GRANULARITY +: GRANULARITY];
                     end
                  end
               end
            end else begin
               data_d = '0;
               if (idx_ro) data_d = WB_DATA_WIDTH'(value_i);
               for (int unsigned k = 0; k < NUM_REGS - 1; k++) begin
                  if (idx == IW'(k)) data_d = regs_q[k];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         pulse_q <= '0;
         data_q  <= '0;
         for (int unsigned k = 0; k < NUM_REGS - 1; k++) regs_q[k] <= '0;
`ifdef WB_REG_BANK_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         pulse_q <= pulse_d;
         data_q  <= data_d;
         regs_q  <= regs_d;
`ifdef WB_REG_BANK_ERR_EN
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < NUM_REGS - 1; k++) regs_o[k*WB_DATA_WIDTH +: WB_DATA_WIDTH] = regs_q[k];
   end

   assign data_o     = data_q;
   assign ack_o      = ack_q;
   assign wr_pulse_o = pulse_q;
`ifdef WB_REG_BANK_ERR_EN
   assign err_o      = err_q;
`endif

endmodule

// File: tb/tb_wb_reg_bank_slave.sv
// Scoreboard bench for wb_reg_bank_slave: driver queues expected responses from a register-array model,
// a negedge monitor pops and compares on every acknowledge.
module tb_wb_reg_bank_slave;
   localparam int WS = 1;

   logic        clk = 1'b0;
   logic        rst, cyc, stb, we;
   logic [10:0] addr;
   logic [3:0]  sel;
   logic [31:0] din, dout;
   logic        ack, err;
   logic [95:0] regs;
   logic [2:0]  pulse;
   logic [15:0] value;

   wb_reg_bank_slave #(
      .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(11), .GRANULARITY(8), .SLAVE_ADDR_WIDTH(1),
      .SLAVE_ADDR(0), .NUM_REGS(4), .WAIT_STATES(WS)
   ) dut (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .addr_i(addr),
      .sel_i(sel), .data_i(din), .data_o(dout), .ack_o(ack),
`ifdef WB_REG_BANK_ERR_EN
      .err_o(err),
`endif
      .regs_o(regs), .wr_pulse_o(pulse), .value_i(value)
   );
`ifndef WB_REG_BANK_ERR_EN
   assign err = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      bit          is_err;
      bit          rd;
      logic [31:0] data;
      logic [2:0]  pulse;
      logic [95:0] regs;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m [3];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] hold = '0;
   bit          clr_pending = 1'b0;

   function automatic logic [95:0] flat();
      return {m[2], m[1], m[0]};
   endfunction

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         clr_pending = 1'b1;
      end else begin
         if (clr_pending) begin
            hold = '0;
            clr_pending = 1'b0;
         end
         if (ack || err) begin
            if (sb.size() == 0) begin
               check("unexpected_ack", {ack, err}, 2'b00);
            end else begin
               e = sb.pop_front();
               check("ack_kind", {ack, err}, e.is_err ? 2'b01 : 2'b10);
               if (e.rd || e.is_err) begin
                  check("read_data", dout, e.data);
                  hold = e.data;
               end else begin
                  check("write_data_hold", dout, hold);
               end
               check("wr_pulse", pulse, e.pulse);
               check("regs_at_ack", regs, e.regs);
            end
         end else begin
            check("pulse_idle", pulse, 3'b000);
            check("data_hold", dout, hold);
         end
      end
   end

   task automatic xfer(input bit w, input logic [1:0] idx, input logic [3:0] s, input logic [31:0] d);
      exp_t        e;
      logic [10:0] a;
      int          n;
      bit          seen;
      a = 11'($urandom);
      a[10] = 1'b0;
      a[3:2] = idx;
      e.is_err = 1'b0;
      e.rd = !w;
      e.data = '0;
      e.pulse = '0;
`ifdef WB_REG_BANK_ERR_EN
      if (w && idx == 2'd3) e.is_err = 1'b1;
`endif
      if (!e.is_err) begin
         if (w) begin
            if (idx < 2'd3) begin
               for (int b = 0; b < 4; b++) if (s[b]) m[idx][8*b +: 8] = d[8*b +: 8];
               if (s != 4'b0) e.pulse[idx] = 1'b1;
            end
         end else begin
            e.data = (idx == 2'd3) ? {16'h0, value} : m[idx];
         end
      end
      e.regs = flat();
      sb.push_back(e);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; addr = a; sel = s; din = d;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (ack || err) seen = 1'b1;
      end
      check("latency", n, WS + 2);
      cyc = 1'b0; stb = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; sel = '0; din = '0; value = '0;
      for (int k = 0; k < 3; k++) m[k] = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_data", dout, 32'h0);
      check("rst_ack", ack, 1'b0);
      check("rst_pulse", pulse, 3'b000);
      check("rst_regs", regs, 96'h0);

      xfer(1'b1, 2'd1, 4'hF, 32'hDEADBEEF);
      xfer(1'b1, 2'd1, 4'b0101, 32'h11223344);
      xfer(1'b0, 2'd1, 4'h0, 32'h0);
      value = 16'h1234;
      xfer(1'b0, 2'd3, 4'hF, 32'h0);
      xfer(1'b1, 2'd3, 4'hF, 32'hFFFFFFFF);
      xfer(1'b0, 2'd3, 4'h3, 32'h0);
      xfer(1'b1, 2'd2, 4'h0, 32'hCAFEF00D);

      // Abort: strobe drops while the slave is waiting.
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 11'h004; sel = 4'hF; din = 32'hA5A5A5A5;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      repeat (5) @(negedge clk);
      check("abort_regs", regs, flat());
      xfer(1'b0, 2'd1, 4'hF, 32'h0);

      // Address outside this slave.
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 11'h404; sel = 4'hF;
      acks = 0;
      repeat (20) begin
         @(negedge clk);
         if (ack || err) acks++;
      end
      check("foreign_addr_acks", acks, 0);
      cyc = 1'b0; stb = 1'b0;

      // Reset during a wait state.
      xfer(1'b1, 2'd0, 4'hF, 32'h00000055);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 11'h008; sel = 4'hF; din = 32'h77777777;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; cyc = 1'b0; stb = 1'b0;
      for (int k = 0; k < 3; k++) m[k] = '0;
      @(negedge clk);
      check("midrst_ack", ack, 1'b0);
      check("midrst_regs", regs, 96'h0);
      check("midrst_pulse", pulse, 3'b000);

      for (int i = 0; i < 150; i++) begin
         value = 16'($urandom);
         xfer(1'($urandom), 2'($urandom_range(0, 3)), 4'($urandom), $urandom);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
